// File: rtl/mem_fill_arbiter.sv
// rtl/mem_fill_arbiter.sv - shares one pipelined memory between I/D block fills and D-side stores
// Fills issue WORDS sequential reads, then stream returns to the owning side until the last word.
module mem_fill_arbiter #(
   parameter  int WORDS  = 8,
   parameter  int ADDR_W = 16,
   parameter  int DATA_W = 16,
   localparam int WIDX   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_miss_req,
   input  logic [ADDR_W-1:0] i_miss_addr,
   input  logic              d_miss_req,
   input  logic [ADDR_W-1:0] d_miss_addr,
   input  logic              d_wr_req,
   input  logic [ADDR_W-1:0] d_wr_addr,
   input  logic [DATA_W-1:0] d_wr_data,
   output logic [DATA_W-1:0] fill_data,
   output logic [WIDX-1:0]   fill_word,
   output logic              i_fill_valid,
   output logic              d_fill_valid,
   output logic              i_fill_done,
   output logic              d_fill_done,
   output logic              d_wr_ack,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic              busy
);

   localparam int                CNT_W    = WIDX + 1;
   localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * WORDS - 1);
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_ISSUE,
      ST_DRAIN
   } state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;          // 1 = D side owns the fill
   logic              last_miss_q, last_miss_d;  // 1 = D side got the last miss grant
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  icnt_q, icnt_d;
   logic [CNT_W-1:0]  rcnt_q, rcnt_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              d_wr_ack_q, d_wr_ack_d;
   logic              busy_q, busy_d;

   logic              pick;
   logic              fill_phase;
   logic              ret_fire;
   logic              last_ret;

   assign fill_phase = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
   assign ret_fire   = rst_n && fill_phase && mem_rvalid;
   assign last_ret   = (rcnt_q == LAST_IDX);

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_miss_d = last_miss_q;
      base_d      = base_q;
      icnt_d      = icnt_q;
      rcnt_d      = rcnt_q;
      mem_en_d    = 1'b0;
      mem_wr_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      d_wr_ack_d  = 1'b0;
      pick        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (d_wr_req) begin
               state_d     = ST_WRITE;
               mem_en_d    = 1'b1;
               mem_wr_d    = 1'b1;
               mem_addr_d  = d_wr_addr;
               mem_wdata_d = d_wr_data;
               d_wr_ack_d  = 1'b1;
            end else if (i_miss_req || d_miss_req) begin
               // Round-robin only matters on a tie; a lone request is simply granted.
               pick        = (i_miss_req && d_miss_req) ? ~last_miss_q : d_miss_req;
               owner_d     = pick;
               last_miss_d = pick;
               base_d      = (pick ? d_miss_addr : i_miss_addr) & BLK_MASK;
               icnt_d      = '0;
               rcnt_d      = '0;
               state_d     = ST_ISSUE;
               mem_en_d    = 1'b1;
               mem_addr_d  = base_d;
            end
         end
         ST_WRITE: state_d = ST_IDLE;
         ST_ISSUE: begin
            if (icnt_q == LAST_IDX) begin
               state_d = ST_DRAIN;
            end else begin
               icnt_d     = icnt_q + CNT_W'(1);
               mem_en_d   = 1'b1;
               mem_addr_d = base_q + ADDR_W'({icnt_d, 1'b0});
            end
         end
         ST_DRAIN: state_d = state_q;
         default:  state_d = ST_IDLE;
      endcase

      if (ret_fire) begin
         rcnt_d = rcnt_q + CNT_W'(1);
         if (last_ret) begin
            state_d  = ST_IDLE;
            mem_en_d = 1'b0;
         end
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         owner_q     <= 1'b0;
         last_miss_q <= 1'b0;
         base_q      <= '0;
         icnt_q      <= '0;
         rcnt_q      <= '0;
         mem_en_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         d_wr_ack_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_miss_q <= last_miss_d;
         base_q      <= base_d;
         icnt_q      <= icnt_d;
         rcnt_q      <= rcnt_d;
         mem_en_q    <= mem_en_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         d_wr_ack_q  <= d_wr_ack_d;
         busy_q      <= busy_d;
      end
   end

   // Return path is combinational so the word reaches the cache in the cycle memory delivers it.
   assign fill_data    = ret_fire ? mem_rdata : '0;
   assign fill_word    = ret_fire ? rcnt_q[WIDX-1:0] : '0;
   assign i_fill_valid = ret_fire & ~owner_q;
   assign d_fill_valid = ret_fire & owner_q;
   assign i_fill_done  = i_fill_valid & last_ret;
   assign d_fill_done  = d_fill_valid & last_ret;

   assign d_wr_ack  = d_wr_ack_q;
   assign mem_en    = mem_en_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb/tb_mem_fill_arbiter.sv - bench for mem_fill_arbiter with memory model and schedule-based reference
module tb_mem_fill_arbiter;

   localparam int WORDS = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_miss_req = 1'b0, d_miss_req = 1'b0, d_wr_req = 1'b0;
   logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
   logic [15:0] fill_data;
   logic [2:0]  fill_word;
   logic        i_fill_valid, d_fill_valid, i_fill_done, d_fill_done, d_wr_ack;
   logic        mem_en, mem_wr, busy;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        mem_rvalid = 1'b0;

   always #5 clk = ~clk;

   mem_fill_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
      .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
      .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
      .fill_data(fill_data), .fill_word(fill_word),
      .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
      .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_wr_ack(d_wr_ack),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int lat = 3;
   bit force_rv = 0;

   typedef struct {
      int          due;
      logic [15:0] data;
   } ret_t;
   ret_t        rq[$];
   int          ev_q[$];       // 1 = I done, 2 = D done, 3 = store ack
   logic [15:0] addr_q[$];
   logic [15:0] wr_addr_log = '0, wr_data_log = '0;
   int          nval_i = 0, nval_d = 0;

   // Reference state: which transaction is running and when it was granted.
   bit          m_busy = 0, m_fill = 0, m_own_d = 0, m_last_d = 0, prev_rst_low = 1;
   int          m_g = 0, m_nret = 0;
   logic [15:0] m_base = '0, m_waddr = '0, m_wdata = '0;

   function automatic logic [15:0] mem_word(logic [15:0] a);
      return (a * 16'd37) ^ 16'h5A3C;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      ret_t r;
      if (force_rv) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 16'($urandom);
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
         r = rq.pop_front();
         mem_rvalid = 1'b1;
         mem_rdata  = r.data;
      end else begin
         mem_rvalid = 1'b0;
         mem_rdata  = '0;
      end
   end

   task automatic check_cycle();
      logic e_en = 0, e_wr = 0, e_ack = 0, e_busy = 0;
      logic e_iv = 0, e_dv = 0, e_id = 0, e_dd = 0;
      logic [15:0] e_addr = '0, e_wdata = '0, e_fdata = '0;
      logic [2:0]  e_word = '0;
      bit end_txn = 0;
      bit was_free = !m_busy;
      int k;

      if (m_busy && cyc > m_g) begin
         e_busy = 1;
         if (!m_fill) begin
            if (cyc == m_g + 1) begin
               e_en = 1; e_wr = 1; e_ack = 1;
               e_addr = m_waddr; e_wdata = m_wdata;
            end
            end_txn = 1;
         end else begin
            k = cyc - m_g - 1;
            if (k < WORDS) begin
               e_en = 1;
               e_addr = m_base + 16'(2 * k);
            end
            if (mem_rvalid && rst_n) begin
               e_fdata = mem_word(m_base + 16'(2 * m_nret));
               e_word  = 3'(m_nret);
               if (m_own_d) e_dv = 1; else e_iv = 1;
               if (m_nret == WORDS - 1) begin
                  if (m_own_d) e_dd = 1; else e_id = 1;
                  end_txn = 1;
               end
               m_nret++;
            end
         end
      end

      chk("busy", busy, e_busy);
      chk("mem_en", mem_en, e_en);
      chk("d_wr_ack", d_wr_ack, e_ack);
      chk("i_fill_valid", i_fill_valid, e_iv);
      chk("d_fill_valid", d_fill_valid, e_dv);
      chk("i_fill_done", i_fill_done, e_id);
      chk("d_fill_done", d_fill_done, e_dd);
      if (e_en || prev_rst_low) begin
         chk("mem_wr", mem_wr, e_wr);
         chk("mem_addr", mem_addr, e_addr);
      end
      if (e_wr || prev_rst_low) chk("mem_wdata", mem_wdata, e_wdata);
      if (e_iv || e_dv || !rst_n) begin
         chk("fill_data", fill_data, e_fdata);
         chk("fill_word", fill_word, e_word);
      end

      if (mem_en && !mem_wr) begin
         rq.push_back('{cyc + lat, mem_word(mem_addr)});
         addr_q.push_back(mem_addr);
      end
      if (mem_en && mem_wr) begin
         wr_addr_log = mem_addr;
         wr_data_log = mem_wdata;
      end
      if (i_fill_valid) nval_i++;
      if (d_fill_valid) nval_d++;
      if (i_fill_done) begin ev_q.push_back(1); i_miss_req = 0; end
      if (d_fill_done) begin ev_q.push_back(2); d_miss_req = 0; end
      if (d_wr_ack)    begin ev_q.push_back(3); d_wr_req = 0; end

      if (end_txn) m_busy = 0;
      if (!rst_n) begin
         m_busy = 0;
         m_last_d = 0;
      end else if (was_free) begin
         if (d_wr_req) begin
            m_busy = 1; m_fill = 0; m_g = cyc;
            m_waddr = d_wr_addr; m_wdata = d_wr_data;
         end else if (i_miss_req || d_miss_req) begin
            m_own_d  = (i_miss_req && d_miss_req) ? !m_last_d : d_miss_req;
            m_last_d = m_own_d;
            m_busy = 1; m_fill = 1; m_g = cyc; m_nret = 0;
            m_base = (m_own_d ? d_miss_addr : i_miss_addr) & 16'hFFF0;
         end
      end
      prev_rst_low = !rst_n;
   endtask

   always @(negedge clk) begin
      #2;
      check_cycle();
   end

   task automatic wait_quiet(int max, string name);
      int n = 0;
      while ((i_miss_req || d_miss_req || d_wr_req) && n < max) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_timeout"}, (n < max), 1);
      i_miss_req = 0; d_miss_req = 0; d_wr_req = 0;
      repeat (lat + 3) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0; i_miss_req = 0; d_miss_req = 0; d_wr_req = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);
   endtask

   typedef struct {
      bit          side_d;
      logic [15:0] addr;
      int          lat;
      logic [15:0] first_a;
      logic [15:0] last_a;
   } vec_t;

   initial begin
      vec_t tbl[5];
      int   n;
      int   dcount;

      tbl[0] = '{0, 16'h0136, 3, 16'h0130, 16'h013E};
      tbl[1] = '{1, 16'h1234, 1, 16'h1230, 16'h123E};
      tbl[2] = '{0, 16'hFFF8, 2, 16'hFFF0, 16'hFFFE};
      tbl[3] = '{1, 16'hFFFF, 4, 16'hFFF0, 16'hFFFE};
      tbl[4] = '{0, 16'h0000, 1, 16'h0000, 16'h000E};

      // Reset held two cycles while memory claims valid data.
      rst_n = 0;
      force_rv = 1;
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);
      force_rv = 0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         lat = tbl[i].lat;
         addr_q.delete(); ev_q.delete(); nval_i = 0; nval_d = 0;
         if (tbl[i].side_d) begin
            d_miss_addr = tbl[i].addr; d_miss_req = 1;
         end else begin
            i_miss_addr = tbl[i].addr; i_miss_req = 1;
         end
         wait_quiet(200, "tbl");
         chk("tbl_naddr", addr_q.size(), 8);
         chk("tbl_first_addr", addr_q.size() > 0 ? addr_q[0] : 16'hDEAD, tbl[i].first_a);
         chk("tbl_last_addr", addr_q.size() > 7 ? addr_q[7] : 16'hDEAD, tbl[i].last_a);
         chk("tbl_nvalid", tbl[i].side_d ? nval_d : nval_i, 8);
         chk("tbl_done_side", ev_q.size() == 1 ? ev_q[0] : 0, tbl[i].side_d ? 2 : 1);
      end

      // Ties right after reset: D first, then round-robin D,I,D,I.
      lat = 2;
      do_reset();
      ev_q.delete();
      i_miss_addr = 16'h1000; d_miss_addr = 16'h2000;
      i_miss_req = 1; d_miss_req = 1;
      wait_quiet(200, "tie1");
      i_miss_req = 1; d_miss_req = 1;
      wait_quiet(200, "tie2");
      chk("tie_nev", ev_q.size(), 4);
      for (int i = 0; i < 4; i++)
         chk("tie_order", ev_q.size() > i ? ev_q[i] : 0, (i % 2 == 0) ? 2 : 1);

      // Store arriving during an I fill goes out ahead of a pending D miss.
      do_reset();
      ev_q.delete();
      i_miss_addr = 16'h3000; i_miss_req = 1;
      repeat (4) @(negedge clk);
      d_wr_addr = 16'h2000; d_wr_data = 16'hBEEF; d_wr_req = 1;
      d_miss_addr = 16'h4008; d_miss_req = 1;
      wait_quiet(300, "store");
      chk("store_nev", ev_q.size(), 3);
      chk("store_ev0", ev_q.size() > 0 ? ev_q[0] : 0, 1);
      chk("store_ev1", ev_q.size() > 1 ? ev_q[1] : 0, 3);
      chk("store_ev2", ev_q.size() > 2 ? ev_q[2] : 0, 2);
      chk("store_addr", wr_addr_log, 16'h2000);
      chk("store_data", wr_data_log, 16'hBEEF);

      // Reset after the third return of a D fill.
      do_reset();
      lat = 2;
      ev_q.delete(); nval_d = 0; nval_i = 0;
      d_miss_addr = 16'h5550; d_miss_req = 1;
      n = 0;
      while (nval_d < 3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reach3", (n < 100), 1);
      rst_n = 0; d_miss_req = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (12) @(negedge clk);
      dcount = 0;
      foreach (ev_q[i]) if (ev_q[i] == 2) dcount++;
      chk("abort_no_done", dcount, 0);
      chk("abort_nvalid", nval_d, 3);
      addr_q.delete(); nval_i = 0;
      i_miss_addr = 16'h0100; i_miss_req = 1;
      wait_quiet(200, "post_abort");
      chk("post_abort_naddr", addr_q.size(), 8);
      chk("post_abort_addr0", addr_q.size() > 0 ? addr_q[0] : 16'hDEAD, 16'h0100);
      chk("post_abort_nvalid", nval_i, 8);

      // Random traffic at several memory latencies.
      for (int ph = 0; ph < 3; ph++) begin
         lat = (ph == 0) ? 1 : (ph == 1) ? 2 : 5;
         repeat (600) begin
            @(negedge clk);
            if (!i_miss_req && $urandom_range(0, 5) == 0) begin
               i_miss_addr = 16'($urandom); i_miss_req = 1;
            end
            if (!d_miss_req && $urandom_range(0, 5) == 0) begin
               d_miss_addr = 16'($urandom); d_miss_req = 1;
            end
            if (!d_wr_req && $urandom_range(0, 7) == 0) begin
               d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom); d_wr_req = 1;
            end
         end
         wait_quiet(400, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog");
   end

endmodule
